// File: rtl/fill_controller.sv
// Fill stage of the washing-machine controller: drives the inlet valve and dosing
// pump, and latches the water_full / detergent_full qualifiers for the wash FSM.
module fill_controller #(
    parameter int unsigned TICK_DIV     = 20000000,
    parameter int unsigned FILL_TIMEOUT = 30,
    parameter int unsigned DOSE_TIME    = 3,
    parameter int unsigned DEBOUNCE     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic       start,
    input  logic       water_level,
    input  logic       detergent_sensor,
    input  logic       finished,
    output logic       water_valve,
    output logic       detergent_pump,
    output logic       water_full,
    output logic       detergent_full,
    output logic       fill_error,
    output logic [2:0] fill_state
);

    localparam logic [2:0] IDLE       = 3'b000;
    localparam logic [2:0] FILL_WATER = 3'b001;
    localparam logic [2:0] DOSE       = 3'b010;
    localparam logic [2:0] READY      = 3'b011;
    localparam logic [2:0] ERROR      = 3'b100;

    localparam logic [31:0] DIV_LAST     = 32'(TICK_DIV - 1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(FILL_TIMEOUT - 1);
    localparam logic [7:0]  DOSE_LAST    = 8'(DOSE_TIME - 1);
    localparam logic [7:0]  DEB_LAST     = 8'(DEBOUNCE - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] div_cnt;
    logic [7:0]  tick_cnt;
    logic [7:0]  deb_cnt;
    logic        tick;
    logic        deb_done;
    logic        timeout;
    logic        dose_done;
    logic        timing_state;

    assign tick         = (div_cnt == DIV_LAST);
    assign deb_done     = water_level && (deb_cnt == DEB_LAST);
    assign timeout      = tick && (tick_cnt == TIMEOUT_LAST);
    assign dose_done    = tick && (tick_cnt == DOSE_LAST);
    assign timing_state = (state == FILL_WATER) || (state == DOSE);
    assign fill_state   = state;

    // With power off every legal state holds; only an illegal code is recovered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (power && start)
                    state_nxt = FILL_WATER;
            end
            FILL_WATER: begin
                if (power) begin
                    if (deb_done)
                        state_nxt = DOSE;
                    else if (timeout)
                        state_nxt = ERROR;
                end
            end
            DOSE: begin
                if (power && dose_done)
                    state_nxt = detergent_sensor ? READY : ERROR;
            end
            READY: begin
                if (power && finished)
                    state_nxt = IDLE;
            end
            ERROR: begin
                if (power && start)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters restart on every state entry and only run while timing a fill or dose.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            deb_cnt  <= '0;
        end else if (power) begin
            if (state_nxt != state || !timing_state) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                deb_cnt  <= '0;
            end else begin
                div_cnt <= tick ? 32'd0 : div_cnt + 32'd1;
                if (tick)
                    tick_cnt <= tick_cnt + 8'd1;
                if (state == FILL_WATER)
                    deb_cnt <= water_level ? deb_cnt + 8'd1 : 8'd0;
            end
        end
    end

    // Outputs decode the state being entered, so they change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            water_valve    <= 1'b0;
            detergent_pump <= 1'b0;
            water_full     <= 1'b0;
            detergent_full <= 1'b0;
            fill_error     <= 1'b0;
        end else begin
            water_valve    <= power && (state_nxt == FILL_WATER);
            detergent_pump <= power && (state_nxt == DOSE);
            water_full     <= (state_nxt == READY);
            detergent_full <= (state_nxt == READY);
            fill_error     <= (state_nxt == ERROR);
        end
    end

endmodule

// File: doc/fill_controller.md
Name: fill_controller

Overview:
- Upstream stage of the washing-machine controller.
- Runs the inlet water valve and the detergent dosing pump, and produces the debounced, latched water_full / detergent_full qualifiers that the wash FSM waits on before it starts washing.
- Holds those qualifiers until the washer reports finished, then re-arms.
- Flags a fault if the tank fails to fill in time or detergent is not detected after dosing.

Parameters:
- TICK_DIV, 20000000: clk cycles per timing tick (1 s at 20 MHz, same tick the washer uses).
- FILL_TIMEOUT, 30: ticks allowed in FILL_WATER before a fault.
- DOSE_TIME, 3: ticks the dosing pump runs.
- DEBOUNCE, 4: consecutive clk cycles water_level must read 1 to count as full.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- power  in  1  machine power enable
- start  in  1  level/pulse: begin fill cycle; also clears a fault
- water_level  in  1  raw tank-full float switch, 1 = full
- detergent_sensor  in  1  1 = detergent present in drum
- finished  in  1  from wash controller: cycle complete
- water_valve  out  1  inlet valve drive
- detergent_pump  out  1  dosing pump drive
- water_full  out  1  to wash controller
- detergent_full  out  1  to wash controller
- fill_error  out  1  fault indicator
- fill_state  out  3  current state code

Behaviour:
- States and codes:
  - IDLE = 000
  - FILL_WATER = 001
  - DOSE = 010
  - READY = 011
  - ERROR = 100
  - Codes 101-111 go to IDLE on the next edge.
- All outputs are registered. Reset (reset = 0, asynchronous) forces:
  - state = IDLE, all outputs 0
  - tick divider, tick counter and debounce counter = 0
  - This applies from any state, mid-fill included; the valve and pump drop immediately.
- Tick generator:
  - The divider counts 0..TICK_DIV-1 and emits a one-cycle tick when it wraps.
  - The divider, tick counter and debounce counter all clear on every state entry, so the first tick comes exactly TICK_DIV cycles after entry.
- IDLE:
  - Valve, pump, water_full and detergent_full are 0.
  - start = 1 at an edge → FILL_WATER on that edge, and water_valve = 1 after the same edge.
- FILL_WATER:
  - The debounce counter increments on each edge with water_level = 1 and clears to 0 on any edge with water_level = 0.
  - On the edge where it reaches DEBOUNCE → DOSE, with water_valve = 0 and detergent_pump = 1.
  - Otherwise, if the tick counter reaches FILL_TIMEOUT → ERROR. Timeout fires TICK_DIV*FILL_TIMEOUT cycles after entry.
  - If debounce completion and timeout land on the same edge, debounce wins and the block goes to DOSE.
- DOSE:
  - The pump runs for DOSE_TIME ticks.
  - On the edge the tick counter reaches DOSE_TIME, detergent_sensor is sampled:
    - 1 → READY: pump = 0, water_full = 1, detergent_full = 1.
    - 0 → ERROR: pump = 0.
- READY:
  - water_full and detergent_full are held at 1 regardless of later sensor changes (latched).
  - finished = 1 → IDLE, flags cleared on that edge.
  - start is ignored; if start and finished arrive together, finished wins.
- ERROR:
  - fill_error = 1, valve, pump and flags are 0.
  - Leaves only on start = 1 → IDLE, with fill_error cleared on that edge, or on reset.
  - start is level-sensitive, so a start still high one cycle later begins a new fill.
- start in FILL_WATER or DOSE is ignored.
- power = 0:
  - On the next edge water_valve and detergent_pump are forced to 0.
  - State, all counters, water_full, detergent_full and fill_error are frozen.
  - When power returns to 1, actuators take their state-defined values on the next edge and counting resumes from the frozen values.
  - start and finished are ignored while power = 0.
- Counters: 32-bit divider, 8-bit tick counter, 8-bit debounce counter; none may wrap within a legal state.

Test Plan:
All scenarios use TICK_DIV=4, FILL_TIMEOUT=5, DOSE_TIME=2, DEBOUNCE=3.
- Nominal fill:
  - Stimulus: power = 1; start pulse; water_level = 1 from cycle 5; detergent_sensor = 1.
  - Response: valve = 1 from the cycle after start, then 0 at debounce completion; pump = 1 for exactly 8 cycles; then water_full = detergent_full = 1 and fill_state = 011.
- Bounce rejection:
  - Stimulus: water_level toggles 1,1,0,1,1,1.
  - Response: DOSE is entered only on the 6th edge.
- Fill timeout:
  - Stimulus: water_level stuck at 0.
  - Response: after 20 cycles in FILL_WATER, fill_state = 100, fill_error = 1, valve = 0.
  - Then a start pulse → IDLE with fill_error = 0.
- Missing detergent:
  - Stimulus: detergent_sensor = 0 at the end of dosing.
  - Response: ERROR, with water_full = detergent_full = 0.
- Handover:
  - Stimulus: in READY, drop water_level to 0, then assert finished together with start.
  - Response: flags stay 1 until finished, then IDLE with flags 0; the concurrent start is not acted on.
- Power and reset:
  - Stimulus: power = 0 for 10 cycles mid-DOSE.
  - Response: pump = 0 and fill_state frozen at 010; after power returns, the pump completes the remaining dose time.
  - Stimulus: reset = 0 mid-FILL_WATER.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
